draw_tile_grid: RTL and testbench
=================================

// Module: draw_tile_grid
// PURPOSE
//  Parametrised tile-grid renderer: GRID_COLS x GRID_ROWS image tiles plus one movable sprite overlaid on the VGA stream.
//  Sits in the vga_if chain after the background stage and before the mouse/char overlays.
//  Drives one shared tile-ROM bus (tile select + pixel address); delays timing to match ROM_LAT.
// PARAMETERS
//  GRID_COLS   3        tile columns (1..8)
//  GRID_ROWS   3        tile rows (1..8)
//  TILE_W      128      tile width px, power of two
//  TILE_H      128      tile height px
//  TILE_GAP    16       px gap between adjacent tiles, both axes
//  GRID_X0     64       hcount of left edge of tile (0,0)
//  GRID_Y0     64       vcount of top edge of tile (0,0)
//  SPR_W       128      sprite width px, power of two
//  SPR_H       128      sprite height px
//  ROM_LAT     1        tile/sprite ROM read latency, cycles (1..4)
//  KEY_COLOR   12'hF0F  sprite transparent colour (used only with DRAW_TILE_GRID_KEY_EN)
//  ADDR_W      $clog2(TILE_W*TILE_H) (localparam); SEL_W = $clog2(GRID_COLS*GRID_ROWS), min 1
// PORTS
//  clk          in   1       pixel clock
//  rst          in   1       synchronous, active-high reset
//  in           vga_if.in    timing + background rgb
//  out          vga_if.out   timing + composed rgb
//  tile_sel     out  SEL_W   tile index = row*GRID_COLS+col
//  tile_addr    out  ADDR_W  pixel address within selected tile
//  tile_rgb     in   12      tile ROM data, valid ROM_LAT cycles after tile_sel/tile_addr
//  spr_x        in   11      sprite left edge request
//  spr_y        in   11      sprite top edge request
//  spr_en       in   1       sprite visible request
//  spr_addr     out  ADDR_W  sprite pixel address (SPR_W*SPR_H must fit ADDR_W)
//  spr_rgb      in   12      sprite ROM data, ROM_LAT cycles after spr_addr
// BEHAVIOUR
//  Reset: out.* all 0; tile_sel/tile_addr/spr_addr 0; latched sprite pos 0, latched enable 0; pipeline cleared.
//  Stage 0 (comb on in.*): tile hit iff hcount in [GRID_X0+c*(TILE_W+TILE_GAP), +TILE_W) and
//   vcount in [GRID_Y0+r*(TILE_H+TILE_GAP), +TILE_H): half-open, exactly TILE_W x TILE_H px; gaps never hit.
//  Sprite hit iff latched enable and hcount in [sx, sx+SPR_W), vcount in [sy, sy+SPR_H); sums computed 12-bit, no wrap.
//  Addresses: tile_addr = dy*TILE_W + dx, spr_addr = dy*SPR_W + dx (dx,dy offsets within rect); no hit -> addr/sel = 0.
//  Stage 1 (register): tile_sel, tile_addr, spr_addr, hit flags registered; ROM sees address 1 cycle after in.*.
//  Hit flags and in.* (timing + rgb) delayed through a shift line; out.* = in.* delayed exactly ROM_LAT+1 cycles.
//  Composition at output register: sprite hit -> spr_rgb; else tile hit -> tile_rgb; else delayed in.rgb.
//  Blanking (delayed hblnk|vblnk) forces out.rgb = 0 regardless of hits.
//  Sprite latch: spr_x/spr_y/spr_en sampled only when in.hcount==0 && in.vcount==0; constant within a frame (no tearing).
//  Simultaneous sprite/tile hit: sprite wins. Sprite overlapping screen edge: clipped, no wrap.
//  Reset mid-frame: pipeline flushed; output resumes with correct alignment ROM_LAT+1 cycles after rst deassert;
//   sprite invisible until next frame-start sample.
// CONFIGURATION
//  DRAW_TILE_GRID_KEY_EN defined: sprite pixel == KEY_COLOR is transparent; tile or background shows through.
//  Undefined: sprite opaque over its whole rectangle; KEY_COLOR ignored.
// TESTING
//  Defaults, ROM model returns addr[11:0]: hcount=64,vcount=64 -> tile_sel=0, tile_addr=0; out.rgb=12'h000 2 cycles later.
//  hcount=64+127 vs 64+128, vcount=64 -> first tile_addr=127 hit; second no hit, out.rgb = delayed in.rgb (gap).
//  hcount=64+144+5, vcount=64+144+3 -> tile_sel=4, tile_addr=3*128+5=389.
//  spr_x=100,spr_y=100,spr_en=1 changed mid-frame -> no effect until frame start; next frame px(100,100) = spr_rgb, sel ignored.
//  KEY_EN: spr_rgb=12'hF0F over tile 0 -> out.rgb = tile_rgb; without macro -> out.rgb=12'hF0F.
//  ROM_LAT=3 rerun: all timing signals delayed 4 cycles; assert rst mid-line -> outputs 0, alignment restored.

Source files
------------

// File: rtl/draw_tile_grid_if.sv
// VGA stream bundle: raster position, sync, blanking and 12-bit colour for one pixel per clock.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_tile_grid.sv
// Tile-grid renderer with one movable sprite overlaid on the VGA stream; out.* is in.* delayed ROM_LAT+1 cycles.
// Optional DRAW_TILE_GRID_KEY_EN makes sprite pixels equal to KEY_COLOR transparent.
module draw_tile_grid #(
  parameter int          GRID_COLS = 3,
  parameter int          GRID_ROWS = 3,
  parameter int          TILE_W    = 128,
  parameter int          TILE_H    = 128,
  parameter int          TILE_GAP  = 16,
  parameter int          GRID_X0   = 64,
  parameter int          GRID_Y0   = 64,
  parameter int          SPR_W     = 128,
  parameter int          SPR_H     = 128,
  parameter int          ROM_LAT   = 1,
  parameter logic [11:0] KEY_COLOR = 12'hF0F,
  localparam int         ADDR_W    = $clog2(TILE_W * TILE_H),
  localparam int         SEL_W     = (GRID_COLS * GRID_ROWS > 1) ? $clog2(GRID_COLS * GRID_ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  vga_if.in                 in_i,
  vga_if.out                out_o,
  output logic [SEL_W-1:0]  tile_sel_o,
  output logic [ADDR_W-1:0] tile_addr_o,
  input  logic [11:0]       tile_rgb_i,
  input  logic [10:0]       spr_x_i,
  input  logic [10:0]       spr_y_i,
  input  logic              spr_en_i,
  output logic [ADDR_W-1:0] spr_addr_o,
  input  logic [11:0]       spr_rgb_i
);

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef struct packed {
    vga_t vga;
    logic tile_hit;
    logic spr_hit;
  } pix_t;

`ifdef DRAW_TILE_GRID_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic [11:0] h12, v12;
  logic        col_hit, row_hit;
  logic [2:0]  col_idx, row_idx;
  logic [11:0] tdx, tdy;

  assign h12 = {1'b0, in_i.hcount};
  assign v12 = {1'b0, in_i.vcount};

  // Half-open rectangles per column/row; gaps fall outside every range.
  always_comb begin
    col_hit = 1'b0;
    col_idx = '0;
    tdx     = '0;
    for (int c = 0; c < GRID_COLS; c++) begin
      if (h12 >= 12'(GRID_X0 + c * (TILE_W + TILE_GAP)) &&
          h12 <  12'(GRID_X0 + c * (TILE_W + TILE_GAP) + TILE_W)) begin
        col_hit = 1'b1;
        col_idx = 3'(c);
        tdx     = h12 - 12'(GRID_X0 + c * (TILE_W + TILE_GAP));
      end
    end
    row_hit = 1'b0;
    row_idx = '0;
    tdy     = '0;
    for (int r = 0; r < GRID_ROWS; r++) begin
      if (v12 >= 12'(GRID_Y0 + r * (TILE_H + TILE_GAP)) &&
          v12 <  12'(GRID_Y0 + r * (TILE_H + TILE_GAP) + TILE_H)) begin
        row_hit = 1'b1;
        row_idx = 3'(r);
        tdy     = v12 - 12'(GRID_Y0 + r * (TILE_H + TILE_GAP));
      end
    end
  end

  logic              tile_hit_d;
  logic [SEL_W-1:0]  tile_sel_d;
  logic [ADDR_W-1:0] tile_addr_d;

  assign tile_hit_d  = col_hit & row_hit;
  assign tile_sel_d  = tile_hit_d ? SEL_W'(int'(row_idx) * GRID_COLS + int'(col_idx)) : '0;
  assign tile_addr_d = tile_hit_d ? ADDR_W'(int'(tdy) * TILE_W + int'(tdx)) : '0;

  // Frame-start sample is bypassed so pixel (0,0) already sees the new sprite state.
  logic [10:0] spr_x_q, spr_y_q;
  logic        spr_en_q;
  logic        frame_start;
  logic [10:0] sx_eff, sy_eff;
  logic        sen_eff;
  logic [11:0] sx_lo, sx_hi, sy_lo, sy_hi, sdx, sdy;
  logic        spr_hit_d;
  logic [ADDR_W-1:0] spr_addr_d;

  assign frame_start = (in_i.hcount == 11'd0) && (in_i.vcount == 11'd0);
  assign sx_eff      = frame_start ? spr_x_i  : spr_x_q;
  assign sy_eff      = frame_start ? spr_y_i  : spr_y_q;
  assign sen_eff     = frame_start ? spr_en_i : spr_en_q;
  assign sx_lo       = {1'b0, sx_eff};
  assign sy_lo       = {1'b0, sy_eff};
  assign sx_hi       = sx_lo + 12'(SPR_W);
  assign sy_hi       = sy_lo + 12'(SPR_H);
  assign spr_hit_d   = sen_eff && (h12 >= sx_lo) && (h12 < sx_hi) && (v12 >= sy_lo) && (v12 < sy_hi);
  assign sdx         = h12 - sx_lo;
  assign sdy         = v12 - sy_lo;
  assign spr_addr_d  = spr_hit_d ? ADDR_W'(int'(sdy) * SPR_W + int'(sdx)) : '0;

  pix_t pix_d;
  always_comb begin
    pix_d.vga.vcount = in_i.vcount;
    pix_d.vga.vsync  = in_i.vsync;
    pix_d.vga.vblnk  = in_i.vblnk;
    pix_d.vga.hcount = in_i.hcount;
    pix_d.vga.hsync  = in_i.hsync;
    pix_d.vga.hblnk  = in_i.hblnk;
    pix_d.vga.rgb    = in_i.rgb;
    pix_d.tile_hit   = tile_hit_d;
    pix_d.spr_hit    = spr_hit_d;
  end

  pix_t              pipe_q [ROM_LAT];
  vga_t              out_q, out_d;
  logic [SEL_W-1:0]  tile_sel_q;
  logic [ADDR_W-1:0] tile_addr_q, spr_addr_q;
  logic              spr_opaque;
  pix_t              pix_l;

  assign pix_l      = pipe_q[ROM_LAT-1];
  assign spr_opaque = !KEY_EN || (spr_rgb_i != KEY_COLOR);

  always_comb begin
    out_d = pix_l.vga;
    if (pix_l.vga.hblnk || pix_l.vga.vblnk) begin
      out_d.rgb = 12'h000;
    end else if (pix_l.spr_hit && spr_opaque) begin
      out_d.rgb = spr_rgb_i;
    end else if (pix_l.tile_hit) begin
      out_d.rgb = tile_rgb_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= '0;
      out_q       <= '0;
      tile_sel_q  <= '0;
      tile_addr_q <= '0;
      spr_addr_q  <= '0;
      spr_x_q     <= '0;
      spr_y_q     <= '0;
      spr_en_q    <= 1'b0;
    end else begin
      pipe_q[0] <= pix_d;
      for (int i = 1; i < ROM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      out_q       <= out_d;
      tile_sel_q  <= tile_sel_d;
      tile_addr_q <= tile_addr_d;
      spr_addr_q  <= spr_addr_d;
      if (frame_start) begin
        spr_x_q  <= spr_x_i;
        spr_y_q  <= spr_y_i;
        spr_en_q <= spr_en_i;
      end
    end
  end

  assign tile_sel_o   = tile_sel_q;
  assign tile_addr_o  = tile_addr_q;
  assign spr_addr_o   = spr_addr_q;
  assign out_o.vcount = out_q.vcount;
  assign out_o.vsync  = out_q.vsync;
  assign out_o.vblnk  = out_q.vblnk;
  assign out_o.hcount = out_q.hcount;
  assign out_o.hsync  = out_q.hsync;
  assign out_o.hblnk  = out_q.hblnk;
  assign out_o.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_tile_grid.sv
// Scoreboard bench for draw_tile_grid with default geometry; ROM models return a function of the address.
module tb_draw_tile_grid #(parameter int TB_LAT = 1);
  localparam int SW = 4;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_if vin();
  vga_if vout();

  logic [SW-1:0] tile_sel;
  logic [AW-1:0] tile_addr, spr_addr;
  logic [11:0]   tile_rgb, spr_rgb;
  logic [10:0]   spr_x, spr_y;
  logic          spr_en;
  logic          key_mode;

  draw_tile_grid #(.ROM_LAT(TB_LAT)) dut (
    .clk(clk), .rst(rst), .in_i(vin), .out_o(vout),
    .tile_sel_o(tile_sel), .tile_addr_o(tile_addr), .tile_rgb_i(tile_rgb),
    .spr_x_i(spr_x), .spr_y_i(spr_y), .spr_en_i(spr_en),
    .spr_addr_o(spr_addr), .spr_rgb_i(spr_rgb)
  );

  function automatic logic [11:0] t_rom(input logic [SW-1:0] s, input logic [AW-1:0] a);
    return a[11:0] ^ {s, 8'h00};
  endfunction

  function automatic logic [11:0] s_rom(input logic k, input logic [AW-1:0] a);
    return k ? 12'hF0F : ~a[11:0];
  endfunction

  generate
    if (TB_LAT == 1) begin : g_rom_comb
      assign tile_rgb = t_rom(tile_sel, tile_addr);
      assign spr_rgb  = s_rom(key_mode, spr_addr);
    end else begin : g_rom_pipe
      logic [SW-1:0] sp [TB_LAT-1];
      logic [AW-1:0] tp [TB_LAT-1];
      logic [AW-1:0] ap [TB_LAT-1];
      always_ff @(posedge clk) begin
        sp[0] <= tile_sel;
        tp[0] <= tile_addr;
        ap[0] <= spr_addr;
        for (int i = 1; i < TB_LAT - 1; i++) begin
          sp[i] <= sp[i-1];
          tp[i] <= tp[i-1];
          ap[i] <= ap[i-1];
        end
      end
      assign tile_rgb = t_rom(sp[TB_LAT-2], tp[TB_LAT-2]);
      assign spr_rgb  = s_rom(key_mode, ap[TB_LAT-2]);
    end
  endgenerate

  typedef struct packed {
    logic [25:0] tim;
    logic [11:0] rgb;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_sx = 0, m_sy = 0;
  bit   m_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [25:0] out_tim();
    return {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk};
  endfunction

  // Drives one pixel now, predicts its results, then samples 1 time unit after the next edge.
  task automatic step(input int h, input int v, input bit hb = 1'b0, input bit vb = 1'b0);
    logic [11:0]   rgb_in;
    logic          hs, vs;
    bit            thit, shit, opaque;
    logic [SW-1:0] esel;
    logic [AW-1:0] eaddr, esaddr;
    logic [11:0]   sval;
    exp_t          e;
    rgb_in = 12'($urandom);
    hs     = 1'($urandom);
    vs     = 1'($urandom);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.rgb    = rgb_in;
    if (h == 0 && v == 0) begin
      m_sx = int'(spr_x);
      m_sy = int'(spr_y);
      m_en = spr_en;
    end
    thit = 1'b0; esel = '0; eaddr = '0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        if (h >= 64 + c * 144 && h < 64 + c * 144 + 128 && v >= 64 + r * 144 && v < 64 + r * 144 + 128) begin
          thit  = 1'b1;
          esel  = SW'(r * 3 + c);
          eaddr = AW'((v - 64 - r * 144) * 128 + (h - 64 - c * 144));
        end
      end
    end
    shit   = m_en && h >= m_sx && h < m_sx + 128 && v >= m_sy && v < m_sy + 128;
    esaddr = shit ? AW'((v - m_sy) * 128 + (h - m_sx)) : '0;
    sval   = s_rom(key_mode, esaddr);
`ifdef DRAW_TILE_GRID_KEY_EN
    opaque = (sval != 12'hF0F);
`else
    opaque = 1'b1;
`endif
    if (hb || vb)          e.rgb = 12'h000;
    else if (shit && opaque) e.rgb = sval;
    else if (thit)         e.rgb = t_rom(esel, eaddr);
    else                   e.rgb = rgb_in;
    e.tim = {11'(v), vs, vb, 11'(h), hs, hb};
    q.push_back(e);
    @(posedge clk);
    #1;
    check("tile_sel", 32'(tile_sel), 32'(esel));
    check("tile_addr", 32'(tile_addr), 32'(eaddr));
    check("spr_addr", 32'(spr_addr), 32'(esaddr));
    if (q.size() > TB_LAT) begin
      e = q.pop_front();
      check("out_timing", 32'(out_tim()), 32'(e.tim));
      check("out_rgb", 32'(vout.rgb), 32'(e.rgb));
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_rgb", 32'(vout.rgb), 32'h0);
      check("rst_timing", 32'(out_tim()), 32'h0);
      check("rst_sel", 32'(tile_sel), 32'h0);
      check("rst_taddr", 32'(tile_addr), 32'h0);
      check("rst_saddr", 32'(spr_addr), 32'h0);
    end
    rst = 1'b0;
    q.delete();
    m_en = 1'b0;
    m_sx = 0;
    m_sy = 0;
    repeat (TB_LAT) q.push_back('0);
  endtask

  initial begin
    rst = 1'b1;
    vin.hcount = '0; vin.vcount = '0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.rgb = '0;
    spr_x = '0; spr_y = '0; spr_en = 1'b0; key_mode = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    // Tile corners, gaps and grid indexing
    step(64, 64);
    step(64 + 127, 64);
    step(64 + 128, 64);
    step(64 + 144 + 5, 64 + 144 + 3);
    step(63, 64);
    step(64, 63);
    step(64 + 127, 64 + 127);
    step(64 + 128, 64 + 128);
    step(64 + 2 * 144 + 127, 64 + 2 * 144 + 127);
    step(64 + 2 * 144 + 128, 64 + 2 * 144);
    step(64, 64, 1'b1, 1'b0);
    step(100, 100, 1'b0, 1'b1);
    repeat (60) step($urandom_range(0, 520), $urandom_range(0, 520), ($urandom_range(0, 7) == 0), 1'b0);

    // Sprite request mid-frame must wait for the next frame start
    spr_x = 11'd100; spr_y = 11'd100; spr_en = 1'b1;
    step(100, 100);
    step(120, 120);
    step(0, 0);
    step(100, 100);
    step(227, 100);
    step(228, 100);
    step(100, 227);
    step(100, 228);
    step(99, 100);
    spr_x = 11'd300;
    step(100, 100);
    step(300, 100);
    repeat (40) step($urandom_range(0, 520), $urandom_range(0, 520), ($urandom_range(0, 9) == 0), 1'b0);

    // Sprite at right screen edge is clipped, not wrapped
    spr_x = 11'd2000; spr_y = 11'd10;
    step(0, 0);
    step(2047, 10);
    step(0, 10);
    step(2000, 137);
    step(2000, 138);
    step(1999, 10);
    repeat (TB_LAT + 1) step(5, 5);

    // Key colour over tile 0
    key_mode = 1'b1;
    spr_x = 11'd64; spr_y = 11'd64;
    step(0, 0);
    step(64, 64);
    step(100, 70);
    step(300, 300);
    step(30, 30);
    repeat (TB_LAT + 1) step(5, 5, 1'b1, 1'b0);
    key_mode = 1'b0;

    // Reset in the middle of a line
    step(0, 0);
    step(70, 80);
    step(71, 80);
    do_reset(2);
    step(72, 80);
    step(73, 80);
    step(200, 80);
    step(0, 0);
    step(72, 80);
    step(191, 191);
    repeat (TB_LAT + 2) step(600, 600);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
